// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared encodings for the extended data memory
// Rev 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int LANES = 4;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_ext_if.sv
`default_nettype none
// ============================================================================
// dmem_ext_if : access bus between the CPU datapath and the data memory
// Rev 1.0
// ============================================================================
interface dmem_ext_if #(
    parameter int ADDR_W = 11
);
    logic              dm_ena;
    logic              dm_r;
    logic              dm_w;
    logic [1:0]        dm_size;
    logic              dm_sign;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_data_in;
    logic [31:0]       dm_data_out;
    logic              dm_busy;
    logic              dm_err;
    logic [ADDR_W-1:0] dm_err_addr;

    modport master (
        output dm_ena, dm_r, dm_w, dm_size, dm_sign, dm_addr, dm_data_in,
        input  dm_data_out, dm_busy, dm_err, dm_err_addr
    );

    modport slave (
        input  dm_ena, dm_r, dm_w, dm_size, dm_sign, dm_addr, dm_data_in,
        output dm_data_out, dm_busy, dm_err, dm_err_addr
    );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_decode.sv
`default_nettype none
// ============================================================================
// dmem_lane_decode : byte strobes, alignment and lane shift for one access
// Rev 1.0
// ============================================================================
module dmem_lane_decode
    import dmem_pkg::*;
(
    input  wire logic [1:0]       size_i,
    input  wire logic [1:0]       addr_lo_i,
    output logic      [LANES-1:0] strb_o,
    output logic                  aligned_o,
    output logic      [4:0]       shift_o
);

    always_comb begin
        strb_o    = '0;
        aligned_o = 1'b0;
        shift_o   = {addr_lo_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                strb_o    = 4'b0001 << addr_lo_i;
                aligned_o = 1'b1;
            end
            SZ_HALF: begin
                strb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                aligned_o = ~addr_lo_i[0];
            end
            SZ_WORD: begin
                strb_o    = 4'b1111;
                aligned_o = (addr_lo_i == 2'b00);
            end
            default: begin
                strb_o    = '0;
                aligned_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_ext.sv
`default_nettype none
// ============================================================================
// dmem_ext : byte/half/word data memory, falling-edge writes, sticky fault
// Rev 1.0
// ============================================================================
module dmem_ext
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 11,
    parameter int DEPTH_WORDS    = 512,
    parameter int CLEAR_ON_RESET = 1
) (
    input  wire logic   dm_clk,
    input  wire logic   dm_rst_n,
    dmem_ext_if.slave   bus
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int CNT_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]       mem_q [DEPTH_WORDS];
    dm_state_t         state_q, state_d;
    logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic              err_q;
    logic [ADDR_W-1:0] err_addr_q;

    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_busy;
    logic [LANES-1:0]  w_strb;
    logic              w_aligned;
    logic [4:0]        w_shift;
    logic              w_legal;
    logic              w_active;
    logic              w_fault;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [31:0]       w_rd_word;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic              w_we;
    logic [IDX_W-1:0]  w_widx;
    logic [LANES-1:0]  w_wstrb;
    logic [31:0]       w_wdata;

    dmem_lane_decode u_decode (
        .size_i    (bus.dm_size),
        .addr_lo_i (bus.dm_addr[1:0]),
        .strb_o    (w_strb),
        .aligned_o (w_aligned),
        .shift_o   (w_shift)
    );

    assign w_idx      = bus.dm_addr[ADDR_W-1:2];
    assign w_in_range = ({1'b0, w_idx} < (IDX_W+1)'(DEPTH_WORDS));
    assign w_busy     = (state_q == CLEAR);
    assign w_legal    = w_aligned & (bus.dm_size != SZ_ILL) & w_in_range
                        & ~(bus.dm_r & bus.dm_w);
    // Anything presented during the clear is dropped, never flagged.
    assign w_active   = bus.dm_ena & ~w_busy;
    assign w_fault    = w_active & ~w_legal;
    assign w_rd_ok    = w_active & w_legal & bus.dm_r;
    assign w_wr_ok    = w_active & w_legal & bus.dm_w;

    // Load path: align the addressed lane to bit 0, then extend.
    assign w_rd_word  = mem_q[w_in_range ? w_idx : '0];
    assign w_shifted  = w_rd_word >> w_shift;

    always_comb begin
        w_load = w_rd_word;
        case (bus.dm_size)
            SZ_BYTE: w_load = bus.dm_sign ? {{24{w_shifted[7]}}, w_shifted[7:0]}
                                          : {24'h0, w_shifted[7:0]};
            SZ_HALF: w_load = bus.dm_sign ? {{16{w_shifted[15]}}, w_shifted[15:0]}
                                          : {16'h0, w_shifted[15:0]};
            default: w_load = w_rd_word;
        endcase
    end

    assign bus.dm_data_out = w_rd_ok ? w_load : 32'h0;
    assign bus.dm_busy     = w_busy;
    assign bus.dm_err      = err_q;
    assign bus.dm_err_addr = err_addr_q;

    // Single write port shared by the clear sequence and CPU stores.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = w_idx;
        w_wstrb = w_strb;
        w_wdata = bus.dm_data_in << w_shift;
        if (state_q == CLEAR) begin
            w_we    = dm_rst_n;
            w_widx  = IDX_W'(clr_cnt_q);
            w_wstrb = '1;
            w_wdata = '0;
        end else begin
            w_we    = w_wr_ok & dm_rst_n;
        end
    end

    always_ff @(negedge dm_clk) begin
        if (w_we) begin
            for (int k = 0; k < LANES; k++) begin
                if (w_wstrb[k]) begin
                    mem_q[w_widx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == CNT_W'(DEPTH_WORDS - 1)) begin
                    state_d = READY;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            READY:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_ff @(negedge dm_clk or negedge dm_rst_n) begin
        if (!dm_rst_n) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_ff @(negedge dm_clk or negedge dm_rst_n) begin
        if (!dm_rst_n) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (w_fault) begin
            err_q <= 1'b1;
            if (!err_q) begin
                err_addr_q <= bus.dm_addr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ext.sv
`default_nettype none
// ============================================================================
// tb_dmem_ext : directed self-checking bench for dmem_ext
// Rev 1.0
// ============================================================================
module tb_dmem_ext;
    import dmem_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n_edges;
    logic [31:0] rd;

    dmem_ext_if #(.ADDR_W(11)) bus ();

    dmem_ext #(
        .ADDR_W         (11),
        .DEPTH_WORDS    (512),
        .CLEAR_ON_RESET (1)
    ) dut (
        .dm_clk   (clk),
        .dm_rst_n (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic ena, input logic r, input logic w,
                           input logic [1:0] size, input logic sign,
                           input logic [10:0] addr, input logic [31:0] din);
        bus.dm_ena     = ena;
        bus.dm_r       = r;
        bus.dm_w       = w;
        bus.dm_size    = size;
        bus.dm_sign    = sign;
        bus.dm_addr    = addr;
        bus.dm_data_in = din;
    endtask

    task automatic idle();
        set_bus(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 11'h0, 32'h0);
    endtask

    task automatic store(input logic [1:0] size, input logic [10:0] addr, input logic [31:0] din);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b0, 1'b1, size, 1'b0, addr, din);
        @(negedge clk); #1;
        idle();
    endtask

    task automatic load(input logic [1:0] size, input logic sign, input logic [10:0] addr,
                        output logic [31:0] d);
        @(posedge clk); #1;
        set_bus(1'b1, 1'b1, 1'b0, size, sign, addr, 32'h0);
        #1;
        d = bus.dm_data_out;
        @(negedge clk); #1;
        idle();
    endtask

    // Counts falling edges from now until busy is seen low, with a hard bound.
    task automatic count_clear(output int n);
        n = 0;
        while (bus.dm_busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",     {31'h0, bus.dm_busy}, 32'h1);
        chk("rst_err",      {31'h0, bus.dm_err},  32'h0);
        chk("rst_err_addr", {21'h0, bus.dm_err_addr}, 32'h0);
        chk("rst_dout",     bus.dm_data_out, 32'h0);

        // Release reset while a word store sits on the bus for the whole clear
        set_bus(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 11'h010, 32'hDEADBEEF);
        rst_n = 1'b1;
        count_clear(n_edges);
        idle();
        chk("clear_len",      n_edges, 32'd512);
        chk("busy_drop_err",  {31'h0, bus.dm_err}, 32'h0);
        load(SZ_WORD, 1'b0, 11'h7FC, rd);
        chk("ld_7fc_zero",    rd, 32'h0);
        load(SZ_WORD, 1'b0, 11'h010, rd);
        chk("busy_store_dropped", rd, 32'h0);

        // Byte merge into a word, signed/unsigned byte and halfword loads
        store(SZ_WORD, 11'h010, 32'h11223344);
        store(SZ_BYTE, 11'h012, 32'hFFFFFFAA);
        load(SZ_WORD, 1'b0, 11'h010, rd);
        chk("ld_w_010",  rd, 32'h11AA3344);
        load(SZ_BYTE, 1'b1, 11'h013, rd);
        chk("ld_bs_013", rd, 32'h00000011);
        load(SZ_BYTE, 1'b1, 11'h012, rd);
        chk("ld_bs_012", rd, 32'hFFFFFFAA);
        load(SZ_BYTE, 1'b0, 11'h012, rd);
        chk("ld_bu_012", rd, 32'h000000AA);
        load(SZ_HALF, 1'b0, 11'h010, rd);
        chk("ld_hu_010", rd, 32'h00003344);

        // Halfword store into the upper lanes
        store(SZ_HALF, 11'h022, 32'h12348001);
        load(SZ_HALF, 1'b1, 11'h022, rd);
        chk("ld_hs_022", rd, 32'hFFFF8001);
        load(SZ_HALF, 1'b0, 11'h022, rd);
        chk("ld_hu_022", rd, 32'h00008001);
        load(SZ_WORD, 1'b0, 11'h020, rd);
        chk("ld_w_020",  rd, 32'h80010000);
        #1;
        chk("idle_dout", bus.dm_data_out, 32'h0);
        chk("no_err_yet", {31'h0, bus.dm_err}, 32'h0);

        // Misaligned word store
        store(SZ_WORD, 11'h006, 32'hCAFEBABE);
        chk("mis_err",      {31'h0, bus.dm_err}, 32'h1);
        chk("mis_err_addr", {21'h0, bus.dm_err_addr}, 32'h006);
        load(SZ_WORD, 1'b0, 11'h004, rd);
        chk("mis_no_write", rd, 32'h0);

        // Second fault keeps the first address
        load(SZ_HALF, 1'b0, 11'h101, rd);
        chk("mis_h_dout",    rd, 32'h0);
        chk("err_addr_kept", {21'h0, bus.dm_err_addr}, 32'h006);

        // Read and write together
        @(posedge clk); #1;
        set_bus(1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 11'h040, 32'h55555555);
        #1;
        chk("rw_dout", bus.dm_data_out, 32'h0);
        @(negedge clk); #1;
        idle();
        chk("rw_err", {31'h0, bus.dm_err}, 32'h1);
        load(SZ_WORD, 1'b0, 11'h040, rd);
        chk("rw_no_write", rd, 32'h0);

        // Reset in the middle of a clear
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midclr_busy", {31'h0, bus.dm_busy}, 32'h1);
        chk("midclr_err",  {31'h0, bus.dm_err},  32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_clear(n_edges);
        chk("reclear_len", n_edges, 32'd512);
        chk("reclear_err_addr", {21'h0, bus.dm_err_addr}, 32'h0);
        load(SZ_WORD, 1'b0, 11'h010, rd);
        chk("reclear_010", rd, 32'h0);
        load(SZ_WORD, 1'b0, 11'h020, rd);
        chk("reclear_020", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_ext.md
# dmem_ext

Parametrised data memory for the single-cycle CPU, successor to the word-only data memory. It adds byte, halfword and word loads and stores with sign or zero extension, and detects misaligned or illegal accesses with a sticky error flag. After reset it runs a hardware clear sequence that zeroes every word. Read timing and write timing are unchanged from the word-only memory: combinational read, falling-edge write.

## Interface
Parameters:
- `ADDR_W`, default 11: byte-address width.
- `DEPTH_WORDS`, default 512: number of 32-bit words. Must be ≤ 2^(ADDR_W-2).
- `CLEAR_ON_RESET`, default 1: 1 = zero the whole array after reset; 0 = array is left uninitialised and the block is ready immediately.

Ports:
- `dm_clk` in, 1: clock. All state updates on the falling edge.
- `dm_rst_n` in, 1: reset, asynchronous and active-low.
- `dm_ena` in, 1: access enable.
- `dm_r` in, 1: read request.
- `dm_w` in, 1: write request.
- `dm_size` in, 2: access size. 00 byte, 01 halfword, 10 word, 11 illegal.
- `dm_sign` in, 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `dm_addr` in, ADDR_W: byte address.
- `dm_data_in` in, 32: store data, right-justified.
- `dm_data_out` out, 32: load data, extended to 32 bits.
- `dm_busy` out, 1: clear sequence in progress.
- `dm_err` out, 1: sticky error flag.
- `dm_err_addr` out, ADDR_W: address of the first faulting access.

## Operation
- Layout: little-endian. Word index = `dm_addr[ADDR_W-1:2]`. Byte lane k occupies bits [8k+7:8k].
- Valid access:
  - requires `dm_ena` high, exactly one of `dm_r`/`dm_w` high, and `dm_busy` low;
  - requires natural alignment (halfword: `addr[0]`=0; word: `addr[1:0]`=0);
  - requires `dm_size`≠11 and word index < `DEPTH_WORDS`.
- Store: writes only the addressed lanes, taking `dm_data_in[7:0]` (byte) or `[15:0]` (halfword) or all 32 bits (word). Other lanes are unchanged.
- Load: selects the addressed byte or halfword and extends it according to `dm_sign`. A word load returns the word as-is.
- `dm_data_out` is 32'h0 whenever no valid read is presented. The output is never high-Z.
- Fault conditions: `dm_ena` high with any of: misaligned, size 11, index out of range, `dm_r` and `dm_w` both high.
- On a fault:
  - the access is suppressed (no write; output 0);
  - `dm_err` is set;
  - `dm_err_addr` captures `dm_addr`, but only if `dm_err` was 0 (first fault only).
- `dm_err` is cleared only by reset.
- Accesses attempted while `dm_busy` is high are silently dropped and are not errors.
- Clear FSM states:
  - CLEAR: `clr_cnt` counts 0..`DEPTH_WORDS`-1 and one word is zeroed per falling edge. After word `DEPTH_WORDS`-1 → READY.
  - READY: normal operation; the block stays here until reset.
- Reset (asserted at any time, including mid-clear):
  - `clr_cnt`=0, `dm_err`=0, `dm_err_addr`=0;
  - state = CLEAR if `CLEAR_ON_RESET`, else READY;
  - `dm_busy` = `CLEAR_ON_RESET`;
  - a clear interrupted by reset restarts from word 0.

## Timing
- Load latency is zero: `dm_data_out` is combinational from the address and the array.
- A store commits at the falling edge of `dm_clk` inside the cycle it is presented. A load in the following cycle returns the new data.
- The fault flag and captured address update at the same falling edge as the offending access.
- Clear duration: exactly `DEPTH_WORDS` falling edges after `dm_rst_n` rises. `dm_busy` drops at the falling edge that zeroes the last word. The first access is accepted at the next falling edge.
- A falling edge that occurs while `dm_rst_n` is low does not advance the clear.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum {CLEAR, READY};
  - lane-strobe width constant (4).
- Sub-module `dmem_lane_decode` (purely combinational):
  - inputs: `dm_size`, `addr[1:0]`;
  - outputs: 4-bit byte strobe, `aligned` flag, lane-shift amount.
  - used by both the store path and the load path.

## Test plan
- Reset with `CLEAR_ON_RESET`=1 and `DEPTH_WORDS`=512: `dm_busy` high for exactly 512 falling edges. Afterwards, a word load at 0x7FC returns 0.
- Word store of 0x11223344 @0x010, then byte store of 0xAA @0x012: word load @0x010 → 0x11AA3344. Byte load @0x013 with sign=1 → 0x00000011.
- Halfword store 0x8001 @0x022: halfword load @0x022 with sign=1 → 0xFFFF8001; with sign=0 → 0x00008001.
- Word store @0x006 (misaligned): memory unchanged, `dm_err`=1, `dm_err_addr`=0x006. A later halfword access @0x101 leaves `dm_err_addr` at 0x006.
- `dm_r` and `dm_w` both high @0x040: no write occurs, `dm_data_out`=0, `dm_err` is set. A store attempted while `dm_busy` is high is dropped with no error.
- Reset asserted at clear count 100: the clear restarts from word 0 and `dm_busy` lasts the full 512 falling edges after release. Previously written data reads 0.
